// File: rtl/gpu_lite_arb_pkg.sv
// Shared types and constants for the GPU_LITE register-port arbiter.
package gpu_lite_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } arb_state_t;

    localparam logic BANK_TEXTURES = 1'b0;
    localparam logic BANK_BLOCKS   = 1'b1;
    localparam int   STALL_CNT_W   = 16;

endpackage

// File: rtl/gpu_lite_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that did not win last time goes next.
module gpu_lite_rr_pick (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);

    always_comb begin
        any   = |eligible;
        grant = 1'b0;
        if (eligible == 2'b11) begin
            grant = ~last_grant;
        end else if (eligible[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/gpu_lite_reg_arbiter.sv
// Round-robin arbiter from two config requesters onto the single GPU_LITE register bank port.
// state   | meaning
// IDLE    | waiting for an eligible request; grant registered on leaving
// ISSUE   | one-cycle bank strobe and req_ready pulse to the granted requester
// CAPTURE | read data from the bank latched into the response register
// RESP    | rsp_valid held to the granted requester until rsp_ready
import gpu_lite_arb_pkg::*;

module gpu_lite_reg_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   m0_req_valid,
    input  logic                   m0_req_write,
    input  logic [ADDR_W-1:0]      m0_req_addr,
    input  logic [DATA_W-1:0]      m0_req_wdata,
    output logic                   m0_req_ready,
    output logic                   m0_rsp_valid,
    output logic [DATA_W-1:0]      m0_rsp_rdata,
    input  logic                   m0_rsp_ready,
    input  logic                   m1_req_valid,
    input  logic                   m1_req_write,
    input  logic [ADDR_W-1:0]      m1_req_addr,
    input  logic [DATA_W-1:0]      m1_req_wdata,
    output logic                   m1_req_ready,
    output logic                   m1_rsp_valid,
    output logic [DATA_W-1:0]      m1_rsp_rdata,
    input  logic                   m1_rsp_ready,
    input  logic                   frame_busy,
    output logic                   bank_en,
    output logic                   bank_we,
    output logic                   bank_sel,
    output logic [ADDR_W-1:0]      bank_addr,
    output logic [DATA_W-1:0]      bank_wdata,
    input  logic [DATA_W-1:0]      bank_rdata,
    output logic [STALL_CNT_W-1:0] write_stall_cnt
);

    arb_state_t             state;
    arb_state_t             state_nx;
    logic                   grant;
    logic                   last_grant;
    logic                   pick_grant;
    logic                   pick_any;
    logic [1:0]             eligible;
    logic                   g_write;
    logic [ADDR_W-1:0]      g_addr;
    logic [DATA_W-1:0]      g_wdata;
    logic                   g_rsp_ready;
    logic                   stall_now;
    logic [DATA_W-1:0]      rsp_data;
    logic [STALL_CNT_W-1:0] stall_cnt;

    assign eligible[0] = m0_req_valid && (!m0_req_write || !frame_busy);
    assign eligible[1] = m1_req_valid && (!m1_req_write || !frame_busy);

    gpu_lite_rr_pick u_pick (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    // Requests are held until accepted, so the live inputs are stable through ISSUE.
    assign g_write     = grant ? m1_req_write : m0_req_write;
    assign g_addr      = grant ? m1_req_addr  : m0_req_addr;
    assign g_wdata     = grant ? m1_req_wdata : m0_req_wdata;
    assign g_rsp_ready = grant ? m1_rsp_ready : m0_rsp_ready;

    assign stall_now = frame_busy &&
                       ((m0_req_valid && m0_req_write) || (m1_req_valid && m1_req_write));

    assign write_stall_cnt = stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            rsp_data   <= '0;
            stall_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && pick_any) begin
                grant <= pick_grant;
            end
            if (state == ISSUE) begin
                last_grant <= grant;
                rsp_data   <= '0;
            end
            if (state == CAPTURE) begin
                rsp_data <= bank_rdata;
            end
            if (stall_now && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx     = state;
        bank_en      = 1'b0;
        bank_we      = 1'b0;
        bank_sel     = BANK_TEXTURES;
        bank_addr    = '0;
        bank_wdata   = '0;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        m0_rsp_valid = 1'b0;
        m1_rsp_valid = 1'b0;
        m0_rsp_rdata = '0;
        m1_rsp_rdata = '0;
        case (state)
            IDLE: begin
                if (pick_any) state_nx = ISSUE;
            end
            ISSUE: begin
                bank_en      = 1'b1;
                bank_we      = g_write;
                bank_sel     = grant ? BANK_BLOCKS : BANK_TEXTURES;
                bank_addr    = g_addr;
                bank_wdata   = g_wdata;
                m0_req_ready = !grant;
                m1_req_ready = grant;
                state_nx     = g_write ? RESP : CAPTURE;
            end
            CAPTURE: begin
                state_nx = RESP;
            end
            RESP: begin
                m0_rsp_valid = !grant;
                m1_rsp_valid = grant;
                if (grant) m1_rsp_rdata = rsp_data;
                else       m0_rsp_rdata = rsp_data;
                if (g_rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
